reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width of every architectural register.
REQ-002 Parameter NREGS, default 32, number of architectural registers; address width is 5 bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port rs1_addr  input  5  read port 1 register index.
REQ-006 Port rs2_addr  input  5  read port 2 register index.
REQ-007 Port rs1_data  output  XLEN  read port 1 data, combinational.
REQ-008 Port rs2_data  output  XLEN  read port 2 data, combinational.
REQ-009 Port wb_en  input  1  write-back strobe from the WB stage.
REQ-010 Port wb_rd  input  5  write-back destination index.
REQ-011 Port wb_data  input  XLEN  write-back data, i.e. the WB stage's selected ALU or memory result.
REQ-012 Port issue_valid  input  1  decode presents an instruction for issue this cycle.
REQ-013 Port issue_writes  input  1  issuing instruction writes a destination register.
REQ-014 Port issue_rd  input  5  issuing instruction destination index.
REQ-015 Port stall  output  1  issue blocked this cycle, combinational.
REQ-016 Port pending_count  output  6  number of registers currently marked busy.

Function
REQ-017 Storage SHALL be NREGS x XLEN registers plus a busy bit per register.
REQ-018 Index 0 SHALL always read 0 and SHALL never be marked busy.
REQ-019 Writes to index 0 SHALL be discarded.
REQ-020 On a rising edge with wb_en=1 and wb_rd!=0, register[wb_rd] SHALL take wb_data.
REQ-021 Read bypass: when wb_en=1, wb_rd!=0 and wb_rd equals rsN_addr, rsN_data SHALL equal wb_data in the same cycle. Otherwise rsN_data SHALL equal the stored value.
REQ-022 Busy-set: issue is accepted when issue_valid=1 and stall=0. On acceptance with issue_writes=1 and issue_rd!=0, busy[issue_rd] SHALL be 1 from the next cycle.
REQ-023 Busy-clear: wb_en=1 with wb_rd!=0 SHALL clear busy[wb_rd] at the edge.
REQ-024 If busy-set and busy-clear hit the same index in the same cycle, set SHALL win.
REQ-025 Source hazard: rsN_hazard = (rsN_addr!=0) AND busy[rsN_addr] AND NOT (wb_en AND wb_rd==rsN_addr). A register being written back this cycle is bypassed, not stalled.
REQ-026 WAW hazard: waw = issue_writes AND (issue_rd!=0) AND busy[issue_rd] AND NOT (wb_en AND wb_rd==issue_rd).
REQ-027 stall SHALL equal issue_valid AND (rs1_hazard OR rs2_hazard OR waw).
REQ-028 stall SHALL be 0 whenever issue_valid=0.
REQ-029 rs1/rs2 hazard checks SHALL apply to both sources regardless of instruction type; decode zeroes unused source addresses.
REQ-030 pending_count SHALL be a registered population count of busy[31:1]. It updates in the same edge as the busy bits and ranges 0..31.
REQ-031 Write-back to a non-busy register SHALL still update data and SHALL leave busy at 0; no error is flagged.

Reset
REQ-032 While rst=1 at a rising edge, all registers SHALL clear to 0, all busy bits SHALL clear, and pending_count SHALL become 0.
REQ-033 While rst=1, issue and write-back SHALL have no effect.
REQ-034 After reset, stall SHALL be 0 for any issue.
REQ-035 Reset asserted mid-operation SHALL discard all pending busy marks.

Verification
REQ-036 Reset, then write x5=0xDEADBEEF; next cycle read rs1=5 -> rs1_data=0xDEADBEEF; read rs2=0 -> 0.
REQ-037 wb_en=1, wb_rd=7, wb_data=0x12345678 with rs2_addr=7 in the same cycle -> rs2_data=0x12345678 before the edge.
REQ-038 Issue writes x3 (accepted). Next cycle issue with rs1=3 -> stall=1, pending_count=1. Cycle with wb_rd=3 -> stall=0 and rs1_data=wb_data. Following cycle -> pending_count=0.
REQ-039 Issue rd=9 while busy[9]=1 and no wb to x9 -> stall=1 and busy unchanged. Same cycle with wb_rd=9 -> stall=0 and busy[9] remains 1 (set wins).
REQ-040 Issue rd=0 with issue_writes=1 -> pending_count stays 0. Write to x0 with 0xFFFFFFFF -> x0 reads 0.
REQ-041 Mark x1, x2, x4 busy, then assert rst for 1 cycle -> pending_count=0, stall=0, all reads return 0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Integer register file with a busy-bit scoreboard for in-order issue.
// Offers two bypassed read ports, one write-back port, and issue-stall detection.
module reg_file_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            issue_valid,
  input  logic            issue_writes,
  input  logic [4:0]      issue_rd,
  output logic            stall,
  output logic [5:0]      pending_count
);

  localparam int unsigned CW = 6;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    pending_q;
  logic [CW-1:0]    pending_d;

  logic wb_hit;
  logic rs1_hazard;
  logic rs2_hazard;
  logic waw_hazard;
  logic issue_set;

  assign wb_hit = wb_en && (wb_rd != 5'd0);

  // Read ports: x0 is hardwired to zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (wb_hit && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_hit && (wb_rd == rs2_addr)) rs2_data = wb_data;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  // A register being written back this cycle is forwarded, so it never stalls.
  always_comb begin
    rs1_hazard = (rs1_addr != 5'd0) && busy_q[rs1_addr]
                 && !(wb_en && (wb_rd == rs1_addr));
    rs2_hazard = (rs2_addr != 5'd0) && busy_q[rs2_addr]
                 && !(wb_en && (wb_rd == rs2_addr));
    waw_hazard = issue_writes && (issue_rd != 5'd0) && busy_q[issue_rd]
                 && !(wb_en && (wb_rd == issue_rd));
    stall      = issue_valid && (rs1_hazard || rs2_hazard || waw_hazard);
    issue_set  = issue_valid && !stall && issue_writes && (issue_rd != 5'd0);
  end

  // Clear on write-back first so a same-index issue set takes priority.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit)    busy_d[wb_rd]    = 1'b0;
    if (issue_set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_d = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      pending_d = pending_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      if (wb_hit) regs_q[wb_rd] <= wb_data;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending_count = pending_q;

endmodule
